// File: rtl/bus_trig_fill.sv
// ---------------------------------------------------------------------------
// bus_trig_fill
//   Fill engine driven by one channel of a trigger-on-write command register.
//   A rising edge on start latches base/len/pattern/inc and writes len words
//   (constant pattern, or pattern + index when inc=1) to consecutive word
//   addresses starting at base, wrapping at the top of memory. done is raised
//   when the fill completes and held until start falls (4-phase handshake).
//   start falling during a fill aborts it and sets the sticky aborted flag.
//
// Ports
//   bus_clk, bus_reset_l   clock, asynchronous active-low reset
//   start                  command level (rise = go, fall = abort / ack)
//   base, len, pattern,inc fill descriptor, sampled on start rise
//   mem_addr, mem_wr_data  write address / data
//   mem_we, mem_ready      write request held until accepted
//   done                   completion ack level
//   busy                   high while writing
//   aborted                last fill ended by start fall (sticky)
//   count                  words accepted in current / last fill
// ---------------------------------------------------------------------------
module bus_trig_fill #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 32
) (
  input  logic              bus_clk,
  input  logic              bus_reset_l,
  input  logic              start,
  input  logic [AWIDTH-1:0] base,
  input  logic [AWIDTH:0]   len,
  input  logic [DWIDTH-1:0] pattern,
  input  logic              inc,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wr_data,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              done,
  output logic              busy,
  output logic              aborted,
  output logic [AWIDTH:0]   count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_n;
  logic                start_d;
  logic [AWIDTH-1:0]   base_q, base_n;
  logic [AWIDTH:0]     len_q, len_n;
  logic [DWIDTH-1:0]   pattern_q, pattern_n;
  logic                inc_q, inc_n;

  logic [AWIDTH-1:0]   addr_n;
  logic [DWIDTH-1:0]   data_n;
  logic                we_n, done_n, busy_n, aborted_n;
  logic [AWIDTH:0]     count_n;

  logic                rise, fall, accept;
  logic [AWIDTH:0]     count_inc;

  assign rise      = start & ~start_d;
  assign fall      = ~start & start_d;
  assign accept    = mem_we & mem_ready;
  assign count_inc = count + 1'b1;

  // Next-state and next-output logic. Every output is registered, so this
  // block computes the values each register takes at the next edge.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_n   = state;
    base_n    = base_q;
    len_n     = len_q;
    pattern_n = pattern_q;
    inc_n     = inc_q;
    addr_n    = mem_addr;
    data_n    = mem_wr_data;
    we_n      = mem_we;
    done_n    = done;
    aborted_n = aborted;
    count_n   = count;

    unique case (state)
      IDLE: begin
        if (rise) begin
          base_n    = base;
          len_n     = len;
          pattern_n = pattern;
          inc_n     = inc;
          count_n   = '0;
          aborted_n = 1'b0;
          if (len == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = RUN;
            we_n    = 1'b1;
            addr_n  = base;
            data_n  = pattern;
          end
        end
      end

      RUN: begin
        if (fall) begin
          // Abort wins over a simultaneous final accept; a write accepted in
          // this cycle still counts.
          state_n   = IDLE;
          we_n      = 1'b0;
          aborted_n = 1'b1;
          count_n   = accept ? count_inc : count;
        end else if (accept) begin
          count_n = count_inc;
          if (count_inc == len_q) begin
            state_n = DONE;
            we_n    = 1'b0;
            done_n  = 1'b1;
          end else begin
            // Address wraps naturally through truncation to AWIDTH bits.
            addr_n = base_q + count_inc[AWIDTH-1:0];
            data_n = inc_q ? pattern_q + DWIDTH'(count_inc) : pattern_q;
          end
        end
      end

      DONE: begin
        if (!start) begin
          state_n = IDLE;
          done_n  = 1'b0;
        end
      end

      default: begin
        state_n = IDLE;
        we_n    = 1'b0;
        done_n  = 1'b0;
      end
    endcase

    busy_n = (state_n == RUN);
  end

  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    // NOTE: the descriptor latches are reset along with the control state so
    // nothing from an interrupted fill survives a reset.
    if (!bus_reset_l) begin
      state       <= IDLE;
      start_d     <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      pattern_q   <= '0;
      inc_q       <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_we      <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      aborted     <= 1'b0;
      count       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state       <= state_n;
      start_d     <= start;
      base_q      <= base_n;
      len_q       <= len_n;
      pattern_q   <= pattern_n;
      inc_q       <= inc_n;
      mem_addr    <= addr_n;
      mem_wr_data <= data_n;
      mem_we      <= we_n;
      done        <= done_n;
      busy        <= busy_n;
      aborted     <= aborted_n;
      count       <= count_n;
    end
  end

endmodule

// File: tb/tb_bus_trig_fill.sv
// ---------------------------------------------------------------------------
// tb_bus_trig_fill
//   Directed bench for bus_trig_fill: reset values, constant fill, wrapping
//   incrementing fill, zero-length fill, stalled writes, abort, and reset
//   asserted mid-fill. Accepted writes are logged on the falling edge and
//   compared against hand-computed address/data lists.
// ---------------------------------------------------------------------------
module tb_bus_trig_fill;

  logic        bus_clk = 1'b0;
  logic        bus_reset_l;
  logic        start;
  logic [15:0] base;
  logic [16:0] len;
  logic [31:0] pattern;
  logic        inc;
  logic [15:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_we;
  logic        mem_ready;
  logic        done;
  logic        busy;
  logic        aborted;
  logic [16:0] count;

  int total = 0;
  int bad   = 0;

  logic [15:0] log_addr[$];
  logic [31:0] log_data[$];

  bus_trig_fill #(.AWIDTH(16), .DWIDTH(32)) dut (
    .bus_clk     (bus_clk),
    .bus_reset_l (bus_reset_l),
    .start       (start),
    .base        (base),
    .len         (len),
    .pattern     (pattern),
    .inc         (inc),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_we      (mem_we),
    .mem_ready   (mem_ready),
    .done        (done),
    .busy        (busy),
    .aborted     (aborted),
    .count       (count)
  );

  always #5 bus_clk = ~bus_clk;

  // Inputs change 1 ns after the rising edge, so the falling edge sees
  // exactly the values the next rising edge will act on.
  always @(negedge bus_clk) begin
    if (bus_reset_l && mem_we && mem_ready) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wr_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"},    64'(mem_addr),    64'h0);
    check({tag, "_data"},    64'(mem_wr_data), 64'h0);
    check({tag, "_we"},      64'(mem_we),      64'h0);
    check({tag, "_done"},    64'(done),        64'h0);
    check({tag, "_busy"},    64'(busy),        64'h0);
    check({tag, "_aborted"}, 64'(aborted),     64'h0);
    check({tag, "_count"},   64'(count),       64'h0);
  endtask

  logic [15:0] exp_a[4];
  logic [31:0] exp_d[4];
  logic [15:0] p_addr;
  logic [31:0] p_data;
  logic        p_we;
  int          cyc;

  initial begin
    bus_reset_l = 1'b0;
    start       = 1'b0;
    base        = '0;
    len         = '0;
    pattern     = '0;
    inc         = 1'b0;
    mem_ready   = 1'b1;

    // ---- reset values ------------------------------------------------------
    step();
    step();
    check_zero("rst");
    bus_reset_l = 1'b1;
    step();
    check_zero("idle");

    // ---- constant fill: base 0x10, len 4 -----------------------------------
    base = 16'h0010; len = 17'd4; pattern = 32'hA5A5_A5A5; inc = 1'b0;
    log_addr.delete(); log_data.delete();
    start = 1'b1;
    step();                               // edge N: rise sampled
    check("a_we0",   64'(mem_we),      64'h1);
    check("a_busy0", 64'(busy),        64'h1);
    check("a_addr0", 64'(mem_addr),    64'h10);
    check("a_data0", 64'(mem_wr_data), 64'hA5A5_A5A5);
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("a_addr%0d", i), 64'(mem_addr), 64'(16'h10 + i));
      check($sformatf("a_done%0d", i), 64'(done), 64'h0);
    end
    step();                               // last accept
    check("a_done",  64'(done),   64'h1);
    check("a_we_end",64'(mem_we), 64'h0);
    check("a_busy_e",64'(busy),   64'h0);
    check("a_count", 64'(count),  64'd4);
    check("a_nlog",  64'(log_addr.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      check($sformatf("a_log_addr%0d", i), 64'(log_addr[i]), 64'(16'h10 + i));
      check($sformatf("a_log_data%0d", i), 64'(log_data[i]), 64'hA5A5_A5A5);
    end
    step();
    check("a_done_hold", 64'(done), 64'h1);
    start = 1'b0;
    step();
    check("a_done_drop", 64'(done), 64'h0);
    step();

    // ---- incrementing fill with address and data wrap ----------------------
    base = 16'hFFFE; len = 17'd4; pattern = 32'hFFFF_FFFE; inc = 1'b1;
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    exp_d = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    log_addr.delete(); log_data.delete();
    start = 1'b1;
    cyc = 0;
    while (!done && cyc < 20) begin
      step();
      cyc++;
    end
    check("b_done",    64'(done),  64'h1);
    check("b_latency", 64'(cyc),   64'd5);
    check("b_count",   64'(count), 64'd4);
    check("b_nlog",    64'(log_addr.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      check($sformatf("b_log_addr%0d", i), 64'(log_addr[i]), 64'(exp_a[i]));
      check($sformatf("b_log_data%0d", i), 64'(log_data[i]), 64'(exp_d[i]));
    end
    start = 1'b0;
    step();
    step();

    // ---- zero-length fill ---------------------------------------------------
    base = 16'h1234; len = 17'd0; pattern = 32'h5555_5555; inc = 1'b0;
    log_addr.delete(); log_data.delete();
    start = 1'b1;
    step();
    check("c_done",  64'(done),   64'h1);
    check("c_we",    64'(mem_we), 64'h0);
    check("c_busy",  64'(busy),   64'h0);
    check("c_count", 64'(count),  64'd0);
    step();
    check("c_nlog",  64'(log_addr.size()), 64'd0);
    start = 1'b0;
    step();
    check("c_done_drop", 64'(done), 64'h0);
    step();

    // ---- stalled writes: mem_ready 1,0,0,1,... ------------------------------
    base = 16'h0100; len = 17'd3; pattern = 32'h0000_0010; inc = 1'b1;
    log_addr.delete(); log_data.delete();
    start = 1'b1;
    step();
    for (int k = 0; k < 40 && !done; k++) begin
      mem_ready = ((k % 4) == 0) || ((k % 4) == 3);
      p_we   = mem_we;
      p_addr = mem_addr;
      p_data = mem_wr_data;
      step();
      if (p_we && !mem_ready) begin
        check($sformatf("d_stall_addr%0d", k), 64'(mem_addr),    64'(p_addr));
        check($sformatf("d_stall_data%0d", k), 64'(mem_wr_data), 64'(p_data));
      end
    end
    check("d_done",  64'(done),  64'h1);
    check("d_count", 64'(count), 64'd3);
    check("d_nlog",  64'(log_addr.size()), 64'd3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      check($sformatf("d_log_addr%0d", i), 64'(log_addr[i]), 64'(16'h0100 + i));
      check($sformatf("d_log_data%0d", i), 64'(log_data[i]), 64'(32'h10 + i));
    end
    mem_ready = 1'b1;
    start = 1'b0;
    step();
    step();

    // ---- abort after 10 accepts (10th coincides with start fall) -----------
    base = 16'h0200; len = 17'd100; pattern = 32'h0000_1000; inc = 1'b1;
    log_addr.delete(); log_data.delete();
    start = 1'b1;
    step();
    for (int i = 0; i < 9; i++) step();
    check("e_count9", 64'(count), 64'd9);
    start = 1'b0;
    step();
    check("e_we",      64'(mem_we),  64'h0);
    check("e_aborted", 64'(aborted), 64'h1);
    check("e_count",   64'(count),   64'd10);
    check("e_busy",    64'(busy),    64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("e_done%0d", i), 64'(done),   64'h0);
      check($sformatf("e_we%0d", i),   64'(mem_we), 64'h0);
    end
    check("e_nlog", 64'(log_addr.size()), 64'd10);
    if (log_addr.size() == 10) begin
      check("e_last_addr", 64'(log_addr[9]), 64'h209);
      check("e_last_data", 64'(log_data[9]), 64'h1009);
    end
    base = 16'h0000; len = 17'd1;
    start = 1'b1;
    step();
    check("e_clear_aborted", 64'(aborted), 64'h0);
    check("e_rerun_busy",    64'(busy),    64'h1);
    step();
    check("e_rerun_done",    64'(done),    64'h1);
    check("e_rerun_count",   64'(count),   64'd1);
    start = 1'b0;
    step();
    step();

    // ---- asynchronous reset in the middle of a fill ------------------------
    base = 16'h0300; len = 17'd50; pattern = 32'hDEAD_BEEF; inc = 1'b0;
    start = 1'b1;
    step();
    step();
    step();
    check("f_busy_before", 64'(busy), 64'h1);
    bus_reset_l = 1'b0;
    #2;
    check_zero("f_async");
    start = 1'b0;
    step();
    check_zero("f_held");
    bus_reset_l = 1'b1;
    step();
    check_zero("f_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
